// File: rtl/core_pkg.sv
// Shared core definitions: ISA widths, opcode constants, reset vector and the
// fetch packet handed from the front end to decode.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_CUSTOM = 7'b0001011;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with push/pop/flush and an occupancy count.
// Flush takes priority over a same-cycle push or pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && !flush && empty));

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: credit-limited in-order fetch, branch redirect
// with wrong-path squash, and a small queue feeding decode.
module fetch_redirect_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              QUEUE_DEPTH = 2,
  parameter int              CNT_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic [CNT_W-1:0] iq_count, pcq_count;
  logic             iq_empty, pcq_empty;
  fetch_pkt_t       iq_head, iq_wdata;
  logic [XLEN-1:0]  pcq_head;
  logic [CNT_W:0]   credit_used;
  logic             req_fire, rsp_keep, id_fire, redirect_misaligned;

  // Outstanding requests plus queued words may never exceed the queue depth,
  // which is what guarantees every kept response finds a free slot.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, iq_count};
  assign imem_req_valid = !rst && (state_q == FETCH_RUN) && !redirect_valid &&
                          (credit_used < (CNT_W+1)'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign redirect_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign rsp_keep            = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign id_valid     = !iq_empty && !redirect_valid;
  assign id_fire      = id_valid && id_ready;
  assign id_pc        = iq_head.pc;
  assign id_instr     = iq_head.instr;
  assign misalign_err = misalign_q;

  assign iq_wdata = '{pc: pcq_head, instr: imem_rsp_data};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    misalign_d    = misalign_q;

    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Everything still in flight after this cycle belongs to the wrong path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      drop_d     = outstanding_d;
      if (redirect_misaligned) begin
        state_d    = FETCH_HALT;
        misalign_d = 1'b1;
      end
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      misalign_q    <= misalign_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_pkt_t)),
    .CNT_W (CNT_W)
  ) u_instr_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (iq_wdata),
    .pop       (id_fire),
    .flush     (redirect_valid),
    .pop_data  (iq_head),
    .count     (iq_count),
    .empty     (iq_empty)
  );

  // PCs of in-flight requests; never flushed so squashed responses still pop.
  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (XLEN),
    .CNT_W (CNT_W)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .pop_data  (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty)
  );

  a_outstanding_tracks_fifo: assert property (@(posedge clk) disable iff (rst)
    pcq_count == outstanding_q);
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && pcq_empty));

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with a 1-cycle in-order memory model;
// each test starts from reset and compares logged requests/handoffs to hand values.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        misalign_err;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] pend[$];
  logic [31:0] reqLog[$];
  logic [31:0] idLog[$];
  int          reqCycles;
  int          idCycles;
  logic        obsReqValid, obsIdValid, obsMisalign;
  logic [31:0] obsReqAddr, obsIdPc, obsIdInstr;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .misalign_err    (misalign_err)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] logAt(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive at posedge+1, observe at negedge, return at posedge+1.
  task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                               input logic rspEn, input logic idr);
    redirect_valid  = redir;
    redirect_target = tgt;
    id_ready        = idr;
    if (rspEn && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(pend[0]);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    obsReqValid = imem_req_valid;
    obsReqAddr  = imem_req_addr;
    obsIdValid  = id_valid;
    obsIdPc     = id_pc;
    obsIdInstr  = id_instr;
    obsMisalign = misalign_err;
    if (imem_req_valid) reqCycles++;
    if (id_valid) idCycles++;
    if (imem_req_valid && imem_req_ready) begin
      reqLog.push_back(imem_req_addr);
      pend.push_back(imem_req_addr);
    end
    if (id_valid && id_ready) begin
      idLog.push_back(id_pc);
      checkOutput("instr_match", id_instr, memWord(id_pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    reqLog.delete();
    idLog.delete();
    reqCycles = 0;
    idCycles  = 0;
  endtask

  task automatic resetDut(input string tag);
    rst = 1'b1;
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput({tag, "_req_valid"}, 32'(obsReqValid), 32'd0);
    checkOutput({tag, "_id_valid"}, 32'(obsIdValid), 32'd0);
    checkOutput({tag, "_misalign"}, 32'(obsMisalign), 32'd0);
    checkOutput({tag, "_addr"}, obsReqAddr, 32'h0000_0000);
    rst = 1'b0;
    pend.delete();
    clearLogs();
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    id_ready        = 1'b0;
    @(posedge clk);
    #1;

    // Sequential fetch with an always-ready decoder
    resetDut("rst0");
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("seq_req0", logAt(reqLog, 0), 32'h0);
    checkOutput("seq_req1", logAt(reqLog, 1), 32'h4);
    checkOutput("seq_req2", logAt(reqLog, 2), 32'h8);
    checkOutput("seq_id0", logAt(idLog, 0), 32'h0);
    checkOutput("seq_id1", logAt(idLog, 1), 32'h4);
    checkOutput("seq_id2", logAt(idLog, 2), 32'h8);

    // Decode backpressure stalls fetch after two credits are used
    resetDut("rst1");
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_req_count", 32'(reqLog.size()), 32'd2);
    checkOutput("bp_req0", logAt(reqLog, 0), 32'h0);
    checkOutput("bp_req1", logAt(reqLog, 1), 32'h4);
    checkOutput("bp_req_valid", 32'(obsReqValid), 32'd0);
    checkOutput("bp_id_valid", 32'(obsIdValid), 32'd1);
    checkOutput("bp_id_pc_hold", obsIdPc, 32'h0);
    checkOutput("bp_id_instr_hold", obsIdInstr, memWord(32'h0));
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("bp_req2", logAt(reqLog, 2), 32'h8);
    checkOutput("bp_id0", logAt(idLog, 0), 32'h0);
    checkOutput("bp_id1", logAt(idLog, 1), 32'h4);
    checkOutput("bp_id2", logAt(idLog, 2), 32'h8);
    checkOutput("bp_id3", logAt(idLog, 3), 32'hC);

    // Redirect while two requests are in flight
    resetDut("rst2");
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("r2_req_count", 32'(reqLog.size()), 32'd2);
    clearLogs();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    checkOutput("r2_redir_id_valid", 32'(obsIdValid), 32'd0);
    checkOutput("r2_redir_req_valid", 32'(obsReqValid), 32'd0);
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("r2_req0", logAt(reqLog, 0), 32'h100);
    checkOutput("r2_id0", logAt(idLog, 0), 32'h100);
    checkOutput("r2_id1", logAt(idLog, 1), 32'h104);

    // Response for 0x8 lands in the redirect cycle while 0x4 sits queued
    resetDut("rst3");
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("s_pre_id_count", 32'(idLog.size()), 32'd1);
    checkOutput("s_pre_req2", logAt(reqLog, 2), 32'h8);
    clearLogs();
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1);
    checkOutput("s_redir_id_valid", 32'(obsIdValid), 32'd0);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("s_req0", logAt(reqLog, 0), 32'h40);
    checkOutput("s_id0", logAt(idLog, 0), 32'h40);
    checkOutput("s_id1", logAt(idLog, 1), 32'h44);

    // Misaligned redirect halts fetch until reset
    resetDut("rst4");
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h102, 1'b0, 1'b1);
    checkOutput("m_redir_misalign", 32'(obsMisalign), 32'd0);
    clearLogs();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("m_err_set", 32'(obsMisalign), 32'd1);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("m_req_cycles", 32'(reqCycles), 32'd0);
    checkOutput("m_id_cycles", 32'(idCycles), 32'd0);
    checkOutput("m_err_hold", 32'(obsMisalign), 32'd1);
    resetDut("rst5");
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("m_restart_req0", logAt(reqLog, 0), 32'h0);
    checkOutput("m_restart_req1", logAt(reqLog, 1), 32'h4);

    // PC wraps from the top of the address space to zero
    resetDut("rst6");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    checkOutput("w_redir_req_valid", 32'(obsReqValid), 32'd0);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("w_req0", logAt(reqLog, 0), 32'hFFFF_FFFC);
    checkOutput("w_req1", logAt(reqLog, 1), 32'h0000_0000);
    checkOutput("w_id0", logAt(idLog, 0), 32'hFFFF_FFFC);
    checkOutput("w_id1", logAt(idLog, 1), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
